captura_pin: RTL and testbench
==============================

// Module: captura_pin
// PURPOSE
//  Upstream stage of the parking-gate controlador. Captures keypad presses and
//  assembles a 2-digit BCD PIN. Hands the PIN to the controlador as Pin[7:0]
//  together with a one-cycle enterPin strobe.
//  Provides synchronisation, debounce, clear/enter keys and an idle timeout.
//  Entry is allowed only while a vehicle is present and the gate is not blocked.
// PARAMETERS
//  DEBOUNCE  4     cycles TeclaValida must stay high (after sync) to accept a press
//  TIMEOUT   1000  idle cycles with a partial entry before it is discarded
//  TW        10    width of timeout counter (2**TW > TIMEOUT)
// PORTS
//  Clk         in   1  single clock; all state on rising edge
//  Reset       in   1  one clock; reset is asynchronous and active-low
//  Tecla       in   4  key code: 0-9 digit, 4'hA clear, 4'hB enter, 4'hC-F invalid
//  TeclaValida in   1  asynchronous level, high while a key is held; Tecla stable while high
//  Vehiculo    in   1  vehicle present at gate (same signal fed to controlador)
//  Bloqueo     in   1  controlador lockout; inhibits and aborts entry
//  Pin         out  8  last submitted PIN, {first digit, second digit} BCD
//  enterPin    out  1  one-cycle strobe; Pin valid in the same cycle
//  Digitos     out  2  digits currently held (0..2)
//  ErrorTecla  out  1  one-cycle pulse on a rejected key
// BEHAVIOUR
//  Reset (Reset=0, asynchronous):
//   - Pin=8'h00, enterPin=0, Digitos=0, ErrorTecla=0.
//   - State IDLE; synchroniser, debounce and timeout counters cleared.
//  Input synchronisation and debounce:
//   - TeclaValida passes through a 2-flop synchroniser.
//   - Debounce counter counts consecutive high synced cycles; any low resets it.
//   - A press event fires once, in the cycle the count reaches DEBOUNCE.
//   - Tecla is sampled in that same cycle.
//   - No further event until synced TeclaValida has been low for at least 1 cycle.
//   - Raw TeclaValida rising before edge N -> press event at edge N+2+DEBOUNCE.
//   - All outputs produced by that event are registered at that edge.
//  FSM:
//   - States: IDLE, D1 (0 digits), D2 (1 digit), LISTO (2 digits), ENVIO.
//   - IDLE: Digitos=0; press events ignored, no error.
//     Moves to D1 when Vehiculo=1 and Bloqueo=0.
//   - D1/D2 digit: store digit (first -> upper nibble), Digitos+1, advance D1->D2->LISTO.
//   - Clear (4'hA) in D1/D2/LISTO: discard digits, Digitos=0, go to D1, no error.
//   - Enter (4'hB) in LISTO: go to ENVIO.
//   - Enter in D1/D2: ErrorTecla pulse, discard digits, go to D1.
//   - Digit in LISTO: ErrorTecla pulse, held digits kept.
//   - Any 4'hC-F key: ErrorTecla pulse, no state change.
//   - ENVIO (one cycle): Pin<=held digits, enterPin=1, Digitos<=0, then D1.
//   - Pin holds its value until the next ENVIO; never changes otherwise.
//  Timeout:
//   - Counter runs in D2/LISTO and restarts on every press event.
//   - On reaching TIMEOUT: discard digits, Digitos=0, go to D1.
//   - No ErrorTecla on timeout. Counter held at 0 in IDLE/D1/ENVIO.
//  Abort:
//   - Vehiculo=0 or Bloqueo=1, sampled in any non-IDLE state, forces IDLE next cycle.
//   - Digits discarded, enterPin not asserted.
//   - Abort has priority over a same-cycle press event and over ENVIO.
//     ENVIO aborted -> no strobe, Pin unchanged.
//  Pulses: enterPin and ErrorTecla each stay high exactly 1 cycle. Never both high together.
// TESTING
//  1. Vehiculo=1, keys 4,2,B (each held DEBOUNCE+3 cycles, released 3 cycles)
//     -> one enterPin pulse with Pin=8'h42, Digitos 0->1->2->0.
//  2. Key 7 high for DEBOUNCE+1 raw cycles with a 1-cycle low glitch in the middle
//     -> no press event, Digitos=0; same key held cleanly -> exactly one digit stored.
//  3. Keys 5,B -> ErrorTecla pulse, no enterPin, Digitos=0.
//     Then 1,2,3 -> ErrorTecla on the 3rd key, Digitos stays 2.
//  4. Key 9, then no key for TIMEOUT cycles -> Digitos returns to 0, no ErrorTecla.
//     Then 1,2,B -> Pin=8'h12.
//  5. Keys 3,4, Bloqueo=1 in the same cycle as the enter press event
//     -> IDLE, no enterPin, Pin keeps the previous value (8'h12).
//  6. Reset=0 asserted mid-debounce of a key, asynchronously between edges
//     -> outputs 0 immediately; after release no stale press event is generated.

Source files
------------

// File: rtl/captura_pin.sv
// captura_pin: keypad capture front end for the parking-gate controller.
// Syncs, debounces and assembles a 2-digit BCD PIN with enter strobe.
module captura_pin #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int TW       = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Tecla,
  input  logic       TeclaValida,
  input  logic       Vehiculo,
  input  logic       Bloqueo,
  output logic [7:0] Pin,
  output logic       enterPin,
  output logic [1:0] Digitos,
  output logic       ErrorTecla
);

  localparam int CW = $clog2(DEBOUNCE + 2);
  localparam logic [CW-1:0] DB_HIT = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE + 1);
  localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    D1,
    D2,
    LISTO,
    ENVIO
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] db_q, db_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    d1_q, d1_d;
  logic [3:0]    d2_q, d2_d;
  logic [7:0]    pin_q, pin_d;
  logic          enter_q, enter_d;
  logic          err_q, err_d;
  logic [1:0]    dig_q, dig_d;

  logic press;
  logic abort;
  logic is_dig, is_clr, is_ent, is_bad;
  logic in_run;

  // two-flop synchroniser for the asynchronous key-held level
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= TeclaValida;
      s2_q <= s1_q;
    end
  end

  // debounce count saturates one past the hit so each hold fires once
  always_comb begin
    db_d = db_q;
    if (!s2_q) begin
      db_d = '0;
    end else if (db_q != DB_MAX) begin
      db_d = db_q + 1'b1;
    end
  end

  // debounce counter register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      db_q <= '0;
    end else begin
      db_q <= db_d;
    end
  end

  assign press  = s2_q && (db_q == DB_HIT);
  assign abort  = !Vehiculo || Bloqueo;
  assign is_dig = (Tecla <= 4'd9);
  assign is_clr = (Tecla == 4'hA);
  assign is_ent = (Tecla == 4'hB);
  assign is_bad = (Tecla >= 4'hC);
  assign in_run = (state_q == D2) || (state_q == LISTO);

  // entry FSM: next state, digit storage, timeout and output pulses
  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    pin_d   = pin_q;
    enter_d = 1'b0;
    err_d   = 1'b0;
    dig_d   = dig_q;
    tmo_d   = '0;
    if (state_q == IDLE) begin
      dig_d = 2'd0;
      if (!abort) begin
        state_d = D1;
      end
    end else if (abort) begin
      state_d = IDLE;
      dig_d   = 2'd0;
    end else if (state_q == ENVIO) begin
      pin_d   = {d1_q, d2_q};
      enter_d = 1'b1;
      dig_d   = 2'd0;
      state_d = D1;
    end else if (press) begin
      unique case (1'b1)
        is_bad: begin
          err_d = 1'b1;
        end
        is_clr: begin
          dig_d   = 2'd0;
          state_d = D1;
        end
        is_ent: begin
          if (state_q == LISTO) begin
            state_d = ENVIO;
          end else begin
            err_d   = 1'b1;
            dig_d   = 2'd0;
            state_d = D1;
          end
        end
        is_dig: begin
          if (state_q == D1) begin
            d1_d    = Tecla;
            dig_d   = 2'd1;
            state_d = D2;
          end else if (state_q == D2) begin
            d2_d    = Tecla;
            dig_d   = 2'd2;
            state_d = LISTO;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (in_run) begin
      if (tmo_q == TO_HIT) begin
        dig_d   = 2'd0;
        state_d = D1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // FSM state, held digits and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      pin_q   <= 8'h00;
      enter_q <= 1'b0;
      err_q   <= 1'b0;
      dig_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      pin_q   <= pin_d;
      enter_q <= enter_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
    end
  end

  assign Pin        = pin_q;
  assign enterPin   = enter_q;
  assign Digitos    = dig_q;
  assign ErrorTecla = err_q;

endmodule

// File: tb/tb_captura_pin.sv
// tb_captura_pin: directed vector bench for captura_pin.
// Table of key presses plus hand sequences for timing corners.
module tb_captura_pin;

  localparam int DB = 4;
  localparam int TO = 1000;

  logic       Clk;
  logic       Reset;
  logic [3:0] Tecla;
  logic       TeclaValida;
  logic       Vehiculo;
  logic       Bloqueo;
  logic [7:0] Pin;
  logic       enterPin;
  logic [1:0] Digitos;
  logic       ErrorTecla;

  captura_pin #(
    .DEBOUNCE(DB),
    .TIMEOUT (TO),
    .TW      (10)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tecla      (Tecla),
    .TeclaValida(TeclaValida),
    .Vehiculo   (Vehiculo),
    .Bloqueo    (Bloqueo),
    .Pin        (Pin),
    .enterPin   (enterPin),
    .Digitos    (Digitos),
    .ErrorTecla (ErrorTecla)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] key;
    int         dig;
    int         derr;
    int         dent;
    int         pin;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   n_ent = 0;
  int   n_err = 0;
  logic both  = 1'b0;
  logic wide  = 1'b0;
  logic p_ent = 1'b0;
  logic p_err = 1'b0;

  // pulse counters and pulse-shape flags
  always @(negedge Clk) begin
    if (enterPin) n_ent <= n_ent + 1;
    if (ErrorTecla) n_err <= n_err + 1;
    if (enterPin && ErrorTecla) both <= 1'b1;
    if (enterPin && p_ent) wide <= 1'b1;
    if (ErrorTecla && p_err) wide <= 1'b1;
    p_ent <= enterPin;
    p_err <= ErrorTecla;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold,
                       input int rel);
    Tecla       = k;
    TeclaValida = 1'b1;
    repeat (hold) @(negedge Clk);
    TeclaValida = 1'b0;
    repeat (rel) @(negedge Clk);
  endtask

  task automatic apply(input vec_t v, input string nm);
    int e0;
    int r0;
    e0 = n_ent;
    r0 = n_err;
    press(v.key, DB + 3, 3);
    #1;
    chk({nm, " dig"}, int'(Digitos), v.dig);
    chk({nm, " err"}, n_err - r0, v.derr);
    chk({nm, " ent"}, n_ent - e0, v.dent);
    chk({nm, " pin"}, int'(Pin), v.pin);
  endtask

  vec_t tbl[14];

  initial begin
    int e0;
    int r0;
    vec_t v;
    tbl[0]  = '{4'h4, 1, 0, 0, 'h00};
    tbl[1]  = '{4'h2, 2, 0, 0, 'h00};
    tbl[2]  = '{4'hB, 0, 0, 1, 'h42};
    tbl[3]  = '{4'h5, 1, 0, 0, 'h42};
    tbl[4]  = '{4'hB, 0, 1, 0, 'h42};
    tbl[5]  = '{4'h1, 1, 0, 0, 'h42};
    tbl[6]  = '{4'h2, 2, 0, 0, 'h42};
    tbl[7]  = '{4'h3, 2, 1, 0, 'h42};
    tbl[8]  = '{4'hA, 0, 0, 0, 'h42};
    tbl[9]  = '{4'hE, 0, 1, 0, 'h42};
    tbl[10] = '{4'h7, 1, 0, 0, 'h42};
    tbl[11] = '{4'h8, 2, 0, 0, 'h42};
    tbl[12] = '{4'hE, 2, 1, 0, 'h42};
    tbl[13] = '{4'hB, 0, 0, 1, 'h78};

    Tecla       = 4'h0;
    TeclaValida = 1'b0;
    Vehiculo    = 1'b1;
    Bloqueo     = 1'b0;
    Reset       = 1'b1;
    #2 Reset    = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst pin", int'(Pin), 0);
    chk("rst ent", int'(enterPin), 0);
    chk("rst dig", int'(Digitos), 0);
    chk("rst err", int'(ErrorTecla), 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // glitched press never reaches the debounce count
    r0          = n_err;
    Tecla       = 4'h7;
    TeclaValida = 1'b1;
    repeat (2) @(negedge Clk);
    TeclaValida = 1'b0;
    @(negedge Clk);
    TeclaValida = 1'b1;
    repeat (3) @(negedge Clk);
    TeclaValida = 1'b0;
    repeat (5) @(negedge Clk);
    #1;
    chk("glitch dig", int'(Digitos), 0);
    chk("glitch err", n_err - r0, 0);

    // clean press: exact latency, then a long hold fires once
    TeclaValida = 1'b1;
    repeat (DB + 2) @(negedge Clk);
    #1;
    chk("lat early", int'(Digitos), 0);
    @(negedge Clk);
    #1;
    chk("lat hit", int'(Digitos), 1);
    repeat (12) @(negedge Clk);
    TeclaValida = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("hold once", int'(Digitos), 1);
    apply('{4'hA, 0, 0, 0, 'h78}, "clr");

    // idle timeout discards a partial entry silently
    apply('{4'h9, 1, 0, 0, 'h78}, "to9");
    r0 = n_err;
    repeat (TO - 20) @(negedge Clk);
    #1;
    chk("to before", int'(Digitos), 1);
    repeat (40) @(negedge Clk);
    #1;
    chk("to after", int'(Digitos), 0);
    chk("to err", n_err - r0, 0);
    apply('{4'h1, 1, 0, 0, 'h78}, "t4a");
    apply('{4'h2, 2, 0, 0, 'h78}, "t4b");
    apply('{4'hB, 0, 0, 1, 'h12}, "t4c");

    // lockout in the same cycle as the enter event wins
    apply('{4'h3, 1, 0, 0, 'h12}, "t5a");
    apply('{4'h4, 2, 0, 0, 'h12}, "t5b");
    e0          = n_ent;
    Tecla       = 4'hB;
    TeclaValida = 1'b1;
    repeat (DB + 2) @(negedge Clk);
    Bloqueo = 1'b1;
    @(negedge Clk);
    TeclaValida = 1'b0;
    repeat (4) @(negedge Clk);
    #1;
    chk("blk ent", n_ent - e0, 0);
    chk("blk pin", int'(Pin), 'h12);
    chk("blk dig", int'(Digitos), 0);
    apply('{4'hF, 0, 0, 0, 'h12}, "blkF");
    Bloqueo = 1'b0;
    Vehiculo = 1'b0;
    repeat (2) @(negedge Clk);
    apply('{4'h5, 0, 0, 0, 'h12}, "noveh");
    Vehiculo = 1'b1;
    repeat (2) @(negedge Clk);
    apply('{4'h6, 1, 0, 0, 'h12}, "back");

    // asynchronous reset mid-debounce
    r0          = n_err;
    Tecla       = 4'h5;
    TeclaValida = 1'b1;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("arst pin", int'(Pin), 0);
    chk("arst dig", int'(Digitos), 0);
    TeclaValida = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (12) @(negedge Clk);
    #1;
    chk("stale dig", int'(Digitos), 0);
    chk("stale err", n_err - r0, 0);
    apply('{4'h8, 1, 0, 0, 'h00}, "alive");

    chk("both high", int'(both), 0);
    chk("wide pulse", int'(wide), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
